// File: rtl/div_seq.sv
// Sequential 32-bit divider for the EX stage: signed/unsigned, one restoring
// step per cycle, holds the pipeline via stall until the one-cycle ready pulse.
module div_seq #(
  parameter logic [7:0] EXE_DIV_OP  = 8'b0001_1010,
  parameter logic [7:0] EXE_DIVU_OP = 8'b0001_1011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  alucontrol,
  input  logic        start,
  input  logic        annul,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  output logic        stall,
  output logic        ready,
  output logic [63:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] rem_q, rem_d;     // {partial remainder[32:0], quotient/dividend[31:0]}
  logic [31:0] dvsr_q, dvsr_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic        ready_q, ready_d;
  logic [63:0] result_q, result_d;

  logic        isdiv, req, is_signed;
  logic [31:0] mag_a, mag_b;
  logic [32:0] shifted, p_next;
  logic [33:0] diff;
  logic        ge;
  logic [31:0] q_next, q_fin, r_fin;
  logic        unused_msb;

  // Partial remainder stays below the divisor, so its top bit never feeds a step.
  assign unused_msb = rem_q[64];

  always_comb begin
    isdiv     = (alucontrol == EXE_DIV_OP) || (alucontrol == EXE_DIVU_OP);
    req       = start & isdiv & ~annul;
    is_signed = (alucontrol == EXE_DIV_OP);
    mag_a     = (is_signed && opdata1[31]) ? 32'd0 - opdata1 : opdata1;
    mag_b     = (is_signed && opdata2[31]) ? 32'd0 - opdata2 : opdata2;

    shifted = rem_q[63:31];
    diff    = {1'b0, shifted} - {2'b00, dvsr_q};
    ge      = ~diff[33];
    p_next  = ge ? diff[32:0] : shifted;
    q_next  = {rem_q[30:0], ge};
    q_fin   = negq_q ? 32'd0 - q_next : q_next;
    r_fin   = negr_q ? 32'd0 - p_next[31:0] : p_next[31:0];

    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    ready_d  = 1'b0;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (opdata2 == 32'd0) begin
            state_d = S_BYZERO;
          end else begin
            rem_d   = {33'd0, mag_a};
            dvsr_d  = mag_b;
            negq_d  = is_signed & (opdata1[31] ^ opdata2[31]);
            negr_d  = is_signed & opdata1[31];
            cnt_d   = 6'd0;
            state_d = S_ON;
          end
        end
      end
      S_ON: begin
        if (!start || annul) begin
          state_d = S_IDLE;
        end else begin
          rem_d = {p_next, q_next};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d  = S_END;
            ready_d  = 1'b1;
            result_d = {r_fin, q_fin};
          end
        end
      end
      S_BYZERO: begin
        if (!start || annul) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_END;
          ready_d  = 1'b1;
          result_d = 64'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      rem_q    <= 65'd0;
      dvsr_q   <= 32'd0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign stall  = req & ~ready_q;
  assign ready  = ready_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, stall shape, signed fix-up, zero divisor,
// annul, non-div ops, back-to-back issue and reset abort.
module tb_div_seq;

  localparam logic [7:0] DIV  = 8'b0001_1010;
  localparam logic [7:0] DIVU = 8'b0001_1011;
  localparam logic [7:0] ADDU = 8'b0010_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  alucontrol;
  logic        start, annul;
  logic [31:0] opdata1, opdata2;
  logic        stall, ready;
  logic [63:0] result;

  int errors = 0;
  int checks = 0;

  div_seq dut (
    .clk(clk), .rst(rst), .alucontrol(alucontrol), .start(start), .annul(annul),
    .opdata1(opdata1), .opdata2(opdata2), .stall(stall), .ready(ready), .result(result)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issues a divide in the current cycle (cycle 0) and follows it to ready.
  // Returns at the falling edge of the ready cycle.
  task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [63:0] exp_res, input string nm);
    int          lat;
    logic [63:0] got;
    bit          stall_bad;
    lat = -1; got = '0; stall_bad = 0;
    start = 1'b1; annul = 1'b0; alucontrol = op; opdata1 = a; opdata2 = b;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (c <= exp_lat && stall !== ((c == exp_lat) ? 1'b0 : 1'b1)) stall_bad = 1;
      if (ready === 1'b1) begin lat = c; got = result; break; end
      step();
    end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", nm, lat, exp_lat);
    end
    checks++;
    if (got !== exp_res) begin
      errors++; $display("FAIL %s result: got %h expected %h", nm, got, exp_res);
    end
    checks++;
    if (stall_bad) begin
      errors++; $display("FAIL %s stall: waveform wrong, expected high until ready cycle", nm);
    end
  endtask

  // After a ready cycle: drop start, check ready fell and result holds.
  task automatic idle_after(input logic [63:0] exp_res, input string nm);
    step(); start = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || result !== exp_res) begin
      errors++; $display("FAIL %s hold: ready=%b result=%h expected ready=0 result=%h",
                         nm, ready, result, exp_res);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; annul = 1'b0; alucontrol = DIVU; opdata1 = 32'd10; opdata2 = 32'd2;
    step(); step();
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      errors++; $display("FAIL reset state: ready=%b result=%h expected 0/0", ready, result);
    end
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL reset stall: got %b expected 1", stall);
    end
    step(); rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL reset release: stall=%b ready=%b expected 0/0", stall, ready);
    end
  endtask

  task automatic test_divu();
    step();
    do_div(DIVU, 32'd100, 32'd7, 33, {32'd2, 32'd14}, "divu_100_7");
    idle_after({32'd2, 32'd14}, "divu_100_7");
  endtask

  task automatic test_signed();
    step();
    do_div(DIV, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_m7_2");
    step();
    do_div(DIV, 32'd7, 32'hFFFF_FFFE, 33, {32'd1, 32'hFFFF_FFFD}, "div_7_m2");
    step();
    do_div(DIV, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 33, {32'hFFFF_FFFE, 32'd2}, "div_m8_m3");
    idle_after({32'hFFFF_FFFE, 32'd2}, "div_m8_m3");
  endtask

  task automatic test_zero();
    step();
    do_div(DIV, 32'd5, 32'd0, 2, 64'd0, "div_by_zero");
    idle_after(64'd0, "div_by_zero");
  endtask

  task automatic test_overflow();
    step();
    do_div(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'd0, 32'h8000_0000}, "div_ovf");
    idle_after({32'd0, 32'h8000_0000}, "div_ovf");
  endtask

  task automatic test_annul();
    bit seen;
    seen = 0;
    step();
    start = 1'b1; annul = 1'b0; alucontrol = DIVU; opdata1 = 32'd1000; opdata2 = 32'd3;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); if (ready === 1'b1) seen = 1;
      step();
    end
    annul = 1'b1;
    @(negedge clk);
    if (ready === 1'b1) seen = 1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL annul stall: got %b expected 0", stall);
    end
    step();
    do_div(DIVU, 32'd9, 32'd3, 33, {32'd0, 32'd3}, "annul_then_9_3");
    checks++;
    if (seen) begin
      errors++; $display("FAIL annul ready: ready pulsed for annulled divide, expected none");
    end
    idle_after({32'd0, 32'd3}, "annul_then_9_3");
  endtask

  task automatic test_nondiv();
    bit bad;
    bad = 0;
    step();
    start = 1'b1; annul = 1'b0; alucontrol = ADDU; opdata1 = 32'd20; opdata2 = 32'd6;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (stall !== 1'b0 || ready !== 1'b0) bad = 1;
      step();
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL nondiv: stall or ready asserted for non-div op, expected 0");
    end
    do_div(DIVU, 32'd20, 32'd6, 33, {32'd2, 32'd3}, "after_nondiv_20_6");
    idle_after({32'd2, 32'd3}, "after_nondiv_20_6");
  endtask

  task automatic test_back_to_back();
    step();
    do_div(DIVU, 32'd50, 32'd5, 33, {32'd0, 32'd10}, "b2b_first");
    step();
    do_div(DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, {32'd1, 32'd1}, "b2b_second");
    step();
    do_div(DIVU, 32'hFFFF_FFFF, 32'd1, 33, {32'd0, 32'hFFFF_FFFF}, "b2b_third");
    idle_after({32'd0, 32'hFFFF_FFFF}, "b2b_third");
  endtask

  task automatic test_rst_abort();
    bit seen, rbad;
    seen = 0; rbad = 0;
    step();
    start = 1'b1; annul = 1'b0; alucontrol = DIVU; opdata1 = 32'd100; opdata2 = 32'd7;
    for (int c = 0; c < 5; c++) step();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL rst stall: got %b expected 1 (follows start)", stall);
    end
    step(); start = 1'b0;
    step(); rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready === 1'b1) seen = 1;
      if (result !== 64'd0) rbad = 1;
      step();
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL rst ready: ready pulsed after abort, expected none");
    end
    checks++;
    if (rbad) begin
      errors++; $display("FAIL rst result: result nonzero after reset, expected 0");
    end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_zero();
    test_overflow();
    test_annul();
    test_nondiv();
    test_back_to_back();
    test_rst_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk drives all state, and rst is sampled only on the rising edge of clk.
REQ-002 clk  in  1  system clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 alucontrol  in  8  EX-stage ALU op code from defines.vh; only EXE_DIV_OP (signed) and EXE_DIVU_OP (unsigned) are acted on.
REQ-005 start  in  1  EX instruction valid; the pipeline holds it and its operands stable while stall=1.
REQ-006 annul  in  1  EX flush (exception or branch squash); aborts any division in progress.
REQ-007 opdata1  in  32  dividend (rs).
REQ-008 opdata2  in  32  divisor (rt).
REQ-009 stall  out  1  pipeline stall request to hazard unit.
REQ-010 ready  out  1  result valid, high for exactly one cycle.
REQ-011 result  out  64  {HI = remainder, LO = quotient}; written into HI/LO by the pipeline when ready=1.

Function
REQ-012 Define isdiv = (alucontrol == EXE_DIV_OP) or (alucontrol == EXE_DIVU_OP), and req = start and isdiv and not annul.
REQ-013 FSM states SHALL be IDLE, BYZERO, ON and END.
REQ-014 IDLE: on req with opdata2 == 0, go to BYZERO; on req with opdata2 != 0, latch |operands| (signed op) or raw operands (unsigned op), latch the sign info, clear the 6-bit counter, and go to ON; otherwise stay in IDLE.
REQ-015 ON: perform one restoring shift-subtract step per cycle on a 65-bit partial remainder and increment the counter; after 32 steps go to END.
REQ-016 BYZERO: go to END after one cycle with quotient = 0 and remainder = 0.
REQ-017 END: drive ready = 1 and result valid for that cycle only, then go to IDLE.
REQ-018 Latency: with req sampled at cycle 0, the block SHALL be in ON for cycles 1..32 and assert ready in cycle 33; for a zero divisor it SHALL assert ready in cycle 2.
REQ-019 stall SHALL be combinational and equal req and not ready, so it is high from cycle 0 until the END cycle, where it is low.
REQ-020 Signed fix-up: if the operand signs differ, the quotient SHALL be negated (two's complement), and the remainder SHALL take the sign of the dividend; all arithmetic is 32-bit wrap.
REQ-021 0x80000000 / 0xFFFFFFFF (signed) SHALL yield LO = 0x80000000 and HI = 0 with no trap.
REQ-022 If annul = 1, or start = 0, in any non-IDLE state, the next state SHALL be IDLE, with ready held low and result not updated.
REQ-023 In BYZERO or END, annul has priority over the normal transition.
REQ-024 When start = 1 with a non-div alucontrol, the block SHALL leave stall at 0 and keep the FSM in IDLE.
REQ-025 Back-to-back divides: the second divide is accepted in the IDLE cycle that follows END, with no lost cycle beyond that IDLE.
REQ-026 result SHALL hold its last value until the next END.

Reset
REQ-027 On rst = 1 at a clock edge: state = IDLE, counter = 0, ready = 0, result = 64'h0, and internal remainder/divisor registers = 0.
REQ-028 rst SHALL override annul and start.
REQ-029 rst SHALL abort an in-progress division in the same edge, and the aborted division SHALL NOT produce a ready pulse.

Verification
REQ-030 Unsigned: DIVU 100/7 -> ready in cycle 33, LO = 14, HI = 2; stall is high in cycles 0..32 and low in cycle 33.
REQ-031 Signed: DIV 0xFFFFFFF9 (-7) / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
REQ-032 Zero divisor: DIV 5/0 -> ready in cycle 2, result = 0.
REQ-033 Annul: annul pulsed in cycle 10 of a DIVU -> no ready pulse, FSM in IDLE at cycle 11; a new DIVU 9/3 accepted in cycle 11 returns LO = 3, HI = 0 in cycle 44.
REQ-034 Overflow and reset: DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0; rst asserted in cycle 5 of another divide -> ready and result stay 0 and stall follows start.
